fp_divider: RTL and testbench

Sequential IEEE-754 single-precision divider, the inverse operation of the FP multiplier in the same arithmetic library. It computes result = a / b with a radix-2 restoring mantissa divider: one quotient bit per cycle, fixed latency, start/busy/done handshake. It uses the multiplier's numeric simplifications: normalized operands only, truncation with no rounding, and flush-to-zero. It sits beside the multiplier in the FP datapath.

---
 rtl/fp_divider_if.sv | 20 ++
 rtl/fp_divider.sv | 125 ++++++++++++
 tb/tb_fp_divider.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_divider_if.sv
// Handshake and operand/result bundle for the sequential binary32 divider.
interface fp_divider_if;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        div_by_zero;

   modport master (
      output start, a, b,
      input  busy, done, result, div_by_zero
   );

   modport slave (
      input  start, a, b,
      output busy, done, result, div_by_zero
   );
endinterface

// File: rtl/fp_divider.sv
// Sequential binary32 divider: radix-2 restoring mantissa divide, one quotient bit per cycle,
// normalized operands only, truncation, flush-to-zero.
module fp_divider (
   input  logic         i_clk,
   input  logic         i_rst_n,
   fp_divider_if.slave  io_div
);
   typedef enum logic [1:0] {StIdle, StDiv, StNorm} state_e;

   state_e      r_state;
   logic [4:0]  r_cnt;
   logic [24:0] r_rem;
   logic [24:0] r_quo;
   logic [23:0] r_div;
   logic [7:0]  r_ea;
   logic [7:0]  r_eb;
   logic        r_sign;
   logic        r_za;
   logic        r_zb;
   logic        r_busy;
   logic        r_done;
   logic        r_dbz;
   logic [31:0] r_result;

   logic        w_accept;
   logic        w_ge;
   logic [24:0] w_rem_sub;
   logic [24:0] w_rem_next;
   logic [9:0]  w_exp;
   logic [22:0] w_mant;
   logic        w_ovf;
   logic        w_unf;
   logic [31:0] w_result;
   logic        w_dbz;

   // NORM also accepts so a held start gives one operation every 26 cycles.
   assign w_accept = io_div.start && (r_state == StIdle || r_state == StNorm);

   always_comb begin
      w_ge       = r_rem >= {1'b0, r_div};
      w_rem_sub  = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;
      w_rem_next = w_rem_sub << 1;
   end

   // Exponent held as 10-bit two's complement; bit 9 flags a negative value.
   always_comb begin
      w_exp  = {2'b00, r_ea} - {2'b00, r_eb} + (r_quo[24] ? 10'd127 : 10'd126);
      w_mant = r_quo[24] ? r_quo[23:1] : r_quo[22:0];
      w_ovf  = !w_exp[9] && (w_exp >= 10'd255);
      w_unf  = w_exp[9] || (w_exp == 10'd0);

      w_result = {r_sign, w_exp[7:0], w_mant};
      w_dbz    = 1'b0;
      if (r_za && r_zb) begin
         w_result = 32'h7FC0_0000;
         w_dbz    = 1'b1;
      end else if (r_zb) begin
         w_result = {r_sign, 8'hFF, 23'd0};
         w_dbz    = 1'b1;
      end else if (r_za) begin
         w_result = {r_sign, 31'd0};
      end else if (w_ovf) begin
         w_result = {r_sign, 8'hFF, 23'd0};
      end else if (w_unf) begin
         w_result = {r_sign, 31'd0};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_cnt    <= 5'd0;
         r_rem    <= 25'd0;
         r_quo    <= 25'd0;
         r_div    <= 24'd0;
         r_ea     <= 8'd0;
         r_eb     <= 8'd0;
         r_sign   <= 1'b0;
         r_za     <= 1'b0;
         r_zb     <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
         r_result <= 32'd0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: ;
            StDiv: begin
               r_busy <= 1'b1;
               r_rem  <= w_rem_next;
               r_quo  <= {r_quo[23:0], w_ge};
               r_cnt  <= r_cnt + 5'd1;
               if (r_cnt == 5'd24) r_state <= StNorm;
            end
            StNorm: begin
               r_result <= w_result;
               r_dbz    <= w_dbz;
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
               r_state  <= StIdle;
            end
            default: r_state <= StIdle;
         endcase

         if (w_accept) begin
            r_sign  <= io_div.a[31] ^ io_div.b[31];
            r_za    <= (io_div.a[30:0] == 31'd0);
            r_zb    <= (io_div.b[30:0] == 31'd0);
            r_ea    <= io_div.a[30:23];
            r_eb    <= io_div.b[30:23];
            r_rem   <= {2'b01, io_div.a[22:0]};
            r_div   <= {1'b1, io_div.b[22:0]};
            r_quo   <= 25'd0;
            r_cnt   <= 5'd0;
            r_state <= StDiv;
         end
      end
   end

   assign io_div.busy        = r_busy;
   assign io_div.done        = r_done;
   assign io_div.result      = r_result;
   assign io_div.div_by_zero = r_dbz;
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench for fp_divider: directed vectors, back-to-back, mid-op reset, random ops.
module tb_fp_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fp_divider_if dif();

   fp_divider dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_div  (dif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        dbz;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Quotient from integer division of the scaled significands, then IEEE field assembly.
   function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      logic              s;
      logic              za;
      logic              zb;
      longint unsigned   num;
      longint unsigned   den;
      longint unsigned   q;
      int                e;
      logic [22:0]       mant;
      s  = a[31] ^ b[31];
      za = (a[30:0] == 31'd0);
      zb = (b[30:0] == 31'd0);
      if (za && zb) return {1'b1, 32'h7FC0_0000};
      if (zb)       return {1'b1, s, 8'hFF, 23'd0};
      if (za)       return {1'b0, s, 31'd0};
      num = {40'd0, 1'b1, a[22:0]};
      den = {40'd0, 1'b1, b[22:0]};
      q   = (num << 24) / den;
      e   = int'(a[30:23]) - int'(b[30:23]) + 126;
      if (q >= 64'h100_0000) begin
         e++;
         mant = q[23:1];
      end else begin
         mant = q[22:0];
      end
      if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
      if (e <= 0)   return {1'b0, s, 31'd0};
      return {1'b0, s, e[7:0], mant};
   endfunction

   function automatic logic [31:0] rand_fp();
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 9) == 0) r[30:0] = 31'd0;
      else if (r[30:23] == 8'd0) r[30:23] = 8'd1;
      return r;
   endfunction

   // Call at #1 after an edge with the DUT idle; returns cycles from accept edge to done.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                         output logic dbz, output int lat, output int busy_bad);
      dif.a = a;
      dif.b = b;
      dif.start = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      dif.a = $urandom;
      dif.b = $urandom;
      lat = 0;
      busy_bad = 0;
      while (lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (dif.done) break;
         if (!dif.busy) busy_bad++;
      end
      if (!dif.done) lat = 99;
      if (dif.busy) busy_bad++;
      res = dif.result;
      dbz = dif.div_by_zero;
   endtask

   logic [31:0] res;
   logic        dbz;
   int          lat;
   int          bbad;
   logic [32:0] exp_v;
   logic [31:0] ops_a[6];
   logic [31:0] ops_b[6];

   initial begin
      vecs[0] = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0};
      vecs[1] = '{32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 1'b0};
      vecs[2] = '{32'hBF80_0000, 32'h3F80_0000, 32'hBF80_0000, 1'b0};
      vecs[3] = '{32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1};
      vecs[4] = '{32'h0000_0000, 32'h8000_0000, 32'h7FC0_0000, 1'b1};
      vecs[5] = '{32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1'b0};
      vecs[6] = '{32'h7F00_0000, 32'h0080_0000, 32'h7F80_0000, 1'b0};
      vecs[7] = '{32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 1'b0};
      vecs[8] = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 1'b0};

      dif.start = 1'b0;
      dif.a = 32'd0;
      dif.b = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", dif.busy, 1'b0);
      check("rst_done", dif.done, 1'b0);
      check("rst_result", dif.result, 32'd0);
      check("rst_dbz", dif.div_by_zero, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, res, dbz, lat, bbad);
         check($sformatf("vec%0d_result", i), res, vecs[i].res);
         check($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
         check($sformatf("vec%0d_latency", i), lat, 26);
         check($sformatf("vec%0d_busy", i), bbad, 0);
      end

      // Back-to-back with start held high; next operands appear mid-operation.
      for (int i = 0; i < 6; i++) begin
         ops_a[i] = rand_fp();
         ops_b[i] = rand_fp();
      end
      dif.a = ops_a[0];
      dif.b = ops_b[0];
      dif.start = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         dif.a = $urandom;
         dif.b = $urandom;
         bbad = 0;
         for (int c = 1; c <= 26; c++) begin
            @(posedge clk);
            #1;
            if (c < 26 && (!dif.busy || dif.done)) bbad++;
            if (c == 13) begin
               if (i < 5) begin
                  dif.a = ops_a[i+1];
                  dif.b = ops_b[i+1];
               end else begin
                  dif.start = 1'b0;
               end
            end
         end
         exp_v = ref_div(ops_a[i], ops_b[i]);
         check($sformatf("b2b%0d_done", i), dif.done, 1'b1);
         check($sformatf("b2b%0d_busy_low", i), dif.busy, 1'b0);
         check($sformatf("b2b%0d_busy_held", i), bbad, 0);
         check($sformatf("b2b%0d_out", i), {dif.div_by_zero, dif.result}, exp_v);
      end
      @(posedge clk);
      #1;

      // Reset in the middle of an operation.
      dif.a = 32'h40C0_0000;
      dif.b = 32'h4000_0000;
      dif.start = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", dif.busy, 1'b0);
      check("midrst_done", dif.done, 1'b0);
      check("midrst_result", dif.result, 32'd0);
      check("midrst_dbz", dif.div_by_zero, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bbad = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dif.done || dif.busy) bbad++;
      end
      check("midrst_no_done", bbad, 0);
      run_op(32'h3F80_0000, 32'h4040_0000, res, dbz, lat, bbad);
      check("postrst_result", {dbz, res}, {1'b0, 32'h3EAA_AAAA});
      check("postrst_latency", lat, 26);

      // Random operands against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = rand_fp();
         rb = rand_fp();
         exp_v = ref_div(ra, rb);
         run_op(ra, rb, res, dbz, lat, bbad);
         check($sformatf("rnd%0d_%h_%h", i, ra, rb), {dbz, res}, exp_v);
         check($sformatf("rnd%0d_latency", i), lat, 26);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
